// File: rtl/qpu_exu_dispatch_if.sv
// Decoder / ALU / OITF bundle for the QPU execution-unit dispatch stage.
// slave = dispatch stage, master = surrounding decoder, ALU and FIFOs.
interface qpu_exu_dispatch_if #(
  parameter int XLEN         = 32,
  parameter int RFIDX_W      = 5,
  parameter int DECINFO_W    = 32,
  parameter int PC_SIZE      = 32,
  parameter int TIME_W       = 32,
  parameter int QUBIT_NUM    = 8,
  parameter int EVENT_WIRE_W = 66,
  parameter int EVENT_NUM    = 8,
  parameter int TQGL_W       = 48
);
  logic                    disp_i_valid;
  logic                    disp_i_ready;
  logic                    disp_i_rs1x0;
  logic                    disp_i_rs2x0;
  logic                    disp_i_rs1en;
  logic                    disp_i_rs2en;
  logic                    disp_i_rdwen;
  logic [RFIDX_W-1:0]      disp_i_rs1idx;
  logic [RFIDX_W-1:0]      disp_i_rs2idx;
  logic [RFIDX_W-1:0]      disp_i_rdidx;
  logic [XLEN-1:0]         disp_i_rs1;
  logic [XLEN-1:0]         disp_i_rs2;
  logic [XLEN-1:0]         disp_i_imm;
  logic [DECINFO_W-1:0]    disp_i_info;
  logic [PC_SIZE-1:0]      disp_i_pc;
  logic                    disp_i_ntp;
  logic                    disp_i_measure;
  logic                    disp_i_nqf;
  logic                    disp_i_fmr;
  logic [TIME_W-1:0]       disp_i_clk;
  logic [QUBIT_NUM-1:0]    disp_i_qmr;
  logic [EVENT_WIRE_W-1:0] disp_i_edata;
  logic [EVENT_NUM-1:0]    disp_i_oprand;
  logic [TQGL_W-1:0]       disp_i_tqgl_pre;
  logic [TQGL_W-1:0]       disp_i_tqgl_cur;

  logic                    disp_o_alu_valid;
  logic                    disp_o_alu_ready;
  logic                    disp_o_alu_longpipe;
  logic [XLEN-1:0]         disp_o_alu_rs1;
  logic [XLEN-1:0]         disp_o_alu_rs2;
  logic                    disp_o_alu_rdwen;
  logic [RFIDX_W-1:0]      disp_o_alu_rdidx;
  logic [DECINFO_W-1:0]    disp_o_alu_info;
  logic [XLEN-1:0]         disp_o_alu_imm;
  logic [PC_SIZE-1:0]      disp_o_alu_pc;
  logic [TIME_W-1:0]       disp_o_alu_clk;
  logic [QUBIT_NUM-1:0]    disp_o_alu_qmr;
  logic [EVENT_WIRE_W-1:0] disp_o_alu_edata;
  logic [EVENT_NUM-1:0]    disp_o_alu_oprand;
  logic [TQGL_W-1:0]       disp_o_alu_tqgl_pre;
  logic [TQGL_W-1:0]       disp_o_alu_tqgl_cur;
  logic                    disp_o_alu_ntp;
  logic                    disp_o_alu_fmr;
  logic                    disp_o_alu_measure;

  logic                    oitfrd_match_disprs1;
  logic                    oitfrd_match_disprs2;
  logic                    oitfrd_match_disprd;
  logic                    oitfqf_match_dispql;

  logic                    disp_oitf_ena;
  logic                    disp_moitf_ena;
  logic                    disp_oitf_ready;
  logic                    disp_moitf_ready;
  logic                    disp_oitf_rs1en;
  logic                    disp_oitf_rs2en;
  logic                    disp_oitf_rdwen;
  logic                    disp_oitf_qfren;
  logic [RFIDX_W-1:0]      disp_oitf_rs1idx;
  logic [RFIDX_W-1:0]      disp_oitf_rs2idx;
  logic [RFIDX_W-1:0]      disp_oitf_rdidx;
  logic [QUBIT_NUM-1:0]    disp_oitf_qubitlist;

  modport slave (
    input  disp_i_valid, disp_i_rs1x0, disp_i_rs2x0,
    input  disp_i_rs1en, disp_i_rs2en, disp_i_rdwen,
    input  disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx,
    input  disp_i_rs1, disp_i_rs2, disp_i_imm,
    input  disp_i_info, disp_i_pc,
    input  disp_i_ntp, disp_i_measure, disp_i_nqf, disp_i_fmr,
    input  disp_i_clk, disp_i_qmr, disp_i_edata, disp_i_oprand,
    input  disp_i_tqgl_pre, disp_i_tqgl_cur,
    input  disp_o_alu_ready, disp_o_alu_longpipe,
    input  oitfrd_match_disprs1, oitfrd_match_disprs2,
    input  oitfrd_match_disprd, oitfqf_match_dispql,
    input  disp_oitf_ready, disp_moitf_ready,
    output disp_i_ready, disp_o_alu_valid,
    output disp_o_alu_rs1, disp_o_alu_rs2,
    output disp_o_alu_rdwen, disp_o_alu_rdidx,
    output disp_o_alu_info, disp_o_alu_imm, disp_o_alu_pc,
    output disp_o_alu_clk, disp_o_alu_qmr,
    output disp_o_alu_edata, disp_o_alu_oprand,
    output disp_o_alu_tqgl_pre, disp_o_alu_tqgl_cur,
    output disp_o_alu_ntp, disp_o_alu_fmr, disp_o_alu_measure,
    output disp_oitf_ena, disp_moitf_ena,
    output disp_oitf_rs1en, disp_oitf_rs2en,
    output disp_oitf_rdwen, disp_oitf_qfren,
    output disp_oitf_rs1idx, disp_oitf_rs2idx,
    output disp_oitf_rdidx, disp_oitf_qubitlist
  );

  modport master (
    output disp_i_valid, disp_i_rs1x0, disp_i_rs2x0,
    output disp_i_rs1en, disp_i_rs2en, disp_i_rdwen,
    output disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx,
    output disp_i_rs1, disp_i_rs2, disp_i_imm,
    output disp_i_info, disp_i_pc,
    output disp_i_ntp, disp_i_measure, disp_i_nqf, disp_i_fmr,
    output disp_i_clk, disp_i_qmr, disp_i_edata, disp_i_oprand,
    output disp_i_tqgl_pre, disp_i_tqgl_cur,
    output disp_o_alu_ready, disp_o_alu_longpipe,
    output oitfrd_match_disprs1, oitfrd_match_disprs2,
    output oitfrd_match_disprd, oitfqf_match_dispql,
    output disp_oitf_ready, disp_moitf_ready,
    input  disp_i_ready, disp_o_alu_valid,
    input  disp_o_alu_rs1, disp_o_alu_rs2,
    input  disp_o_alu_rdwen, disp_o_alu_rdidx,
    input  disp_o_alu_info, disp_o_alu_imm, disp_o_alu_pc,
    input  disp_o_alu_clk, disp_o_alu_qmr,
    input  disp_o_alu_edata, disp_o_alu_oprand,
    input  disp_o_alu_tqgl_pre, disp_o_alu_tqgl_cur,
    input  disp_o_alu_ntp, disp_o_alu_fmr, disp_o_alu_measure,
    input  disp_oitf_ena, disp_moitf_ena,
    input  disp_oitf_rs1en, disp_oitf_rs2en,
    input  disp_oitf_rdwen, disp_oitf_qfren,
    input  disp_oitf_rs1idx, disp_oitf_rs2idx,
    input  disp_oitf_rdidx, disp_oitf_qubitlist
  );
endinterface

// File: rtl/qpu_exu_dispatch.sv
// QPU execution-unit dispatch stage: one-entry hold register with hazard stall.
// Optional macro QPU_DISP_QHAZARD_EN enables qubit-flag hazard stalls.
module qpu_exu_dispatch #(
  parameter int XLEN         = 32,
  parameter int RFIDX_W      = 5,
  parameter int DECINFO_W    = 32,
  parameter int PC_SIZE      = 32,
  parameter int TIME_W       = 32,
  parameter int QUBIT_NUM    = 8,
  parameter int EVENT_WIRE_W = 66,
  parameter int EVENT_NUM    = 8,
  parameter int TQGL_W       = 48
) (
  input logic               clk,
  input logic               rst_n,
  qpu_exu_dispatch_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]         rs1;
    logic [XLEN-1:0]         rs2;
    logic [XLEN-1:0]         imm;
    logic [DECINFO_W-1:0]    info;
    logic [PC_SIZE-1:0]      pc;
    logic [TIME_W-1:0]       tim;
    logic [QUBIT_NUM-1:0]    qmr;
    logic [EVENT_WIRE_W-1:0] edata;
    logic [EVENT_NUM-1:0]    oprand;
    logic [TQGL_W-1:0]       tqgl_pre;
    logic [TQGL_W-1:0]       tqgl_cur;
    logic [RFIDX_W-1:0]      rs1idx;
    logic [RFIDX_W-1:0]      rs2idx;
    logic [RFIDX_W-1:0]      rdidx;
    logic                    rs1en;
    logic                    rs2en;
    logic                    rdwen;
    logic                    ntp;
    logic                    fmr;
    logic                    measure;
    logic                    nqf;
  } hold_t;

  hold_t hold_q;
  hold_t hold_d;
  logic  hold_vld;

  logic dep_oitf;
  logic dep_raw;
  logic dep_qext;
  logic dep_qint;
  logic in_dep;
  logic in_fire;
  logic out_ok;
  logic out_fire;

  // Next hold image: x0 operands are forced to zero on capture.
  always_comb begin
    hold_d          = '0;
    hold_d.rs1      = bus.disp_i_rs1x0 ? '0 : bus.disp_i_rs1;
    hold_d.rs2      = bus.disp_i_rs2x0 ? '0 : bus.disp_i_rs2;
    hold_d.imm      = bus.disp_i_imm;
    hold_d.info     = bus.disp_i_info;
    hold_d.pc       = bus.disp_i_pc;
    hold_d.tim      = bus.disp_i_clk;
    hold_d.qmr      = bus.disp_i_qmr;
    hold_d.edata    = bus.disp_i_edata;
    hold_d.oprand   = bus.disp_i_oprand;
    hold_d.tqgl_pre = bus.disp_i_tqgl_pre;
    hold_d.tqgl_cur = bus.disp_i_tqgl_cur;
    hold_d.rs1idx   = bus.disp_i_rs1idx;
    hold_d.rs2idx   = bus.disp_i_rs2idx;
    hold_d.rdidx    = bus.disp_i_rdidx;
    hold_d.rs1en    = bus.disp_i_rs1en;
    hold_d.rs2en    = bus.disp_i_rs2en;
    hold_d.rdwen    = bus.disp_i_rdwen;
    hold_d.ntp      = bus.disp_i_ntp;
    hold_d.fmr      = bus.disp_i_fmr;
    hold_d.measure  = bus.disp_i_measure;
    hold_d.nqf      = bus.disp_i_nqf;
  end

  // Hazards seen by the OITF for the incoming instruction.
  assign dep_oitf =
      (bus.disp_i_rs1en & bus.oitfrd_match_disprs1)
    | (bus.disp_i_rs2en & bus.oitfrd_match_disprs2)
    | (bus.disp_i_rdwen & bus.oitfrd_match_disprd);

  // The held instruction has not reached the OITF yet, so
  // its destination is checked here against the incoming one.
  assign dep_raw = hold_vld & hold_q.rdwen & (
      (bus.disp_i_rs1en & (hold_q.rdidx == bus.disp_i_rs1idx))
    | (bus.disp_i_rs2en & (hold_q.rdidx == bus.disp_i_rs2idx))
    | (bus.disp_i_rdwen & (hold_q.rdidx == bus.disp_i_rdidx)));

`ifdef QPU_DISP_QHAZARD_EN
  assign dep_qext = bus.disp_i_nqf & bus.oitfqf_match_dispql;
  assign dep_qint = hold_vld & hold_q.measure & bus.disp_i_nqf;
`else
  logic qhaz_unused;
  assign qhaz_unused = bus.oitfqf_match_dispql;
  assign dep_qext    = 1'b0;
  assign dep_qint    = 1'b0;
`endif

  assign in_dep = dep_oitf | dep_raw | dep_qext | dep_qint;

  assign out_ok = hold_vld
    & (~bus.disp_o_alu_longpipe | bus.disp_oitf_ready)
    & (~hold_q.measure | bus.disp_moitf_ready);

  assign out_fire = out_ok & bus.disp_o_alu_ready;
  assign in_fire  = bus.disp_i_valid & bus.disp_i_ready;

  assign bus.disp_i_ready   = ~in_dep & (~hold_vld | out_fire);
  assign bus.disp_o_alu_valid = out_ok;
  assign bus.disp_oitf_ena  = out_fire & bus.disp_o_alu_longpipe;
  assign bus.disp_moitf_ena = out_fire & hold_q.measure;

  // Hold-valid flag: reload wins over drain on a same-cycle swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
    end else if (in_fire) begin
      hold_vld <= 1'b1;
    end else if (out_fire) begin
      hold_vld <= 1'b0;
    end
  end

  // Payload register captures the instruction on every accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (in_fire) begin
      hold_q <= hold_d;
    end
  end

  assign bus.disp_o_alu_rs1      = hold_q.rs1;
  assign bus.disp_o_alu_rs2      = hold_q.rs2;
  assign bus.disp_o_alu_rdwen    = hold_q.rdwen;
  assign bus.disp_o_alu_rdidx    = hold_q.rdidx;
  assign bus.disp_o_alu_info     = hold_q.info;
  assign bus.disp_o_alu_imm      = hold_q.imm;
  assign bus.disp_o_alu_pc       = hold_q.pc;
  assign bus.disp_o_alu_clk      = hold_q.tim;
  assign bus.disp_o_alu_qmr      = hold_q.qmr;
  assign bus.disp_o_alu_edata    = hold_q.edata;
  assign bus.disp_o_alu_oprand   = hold_q.oprand;
  assign bus.disp_o_alu_tqgl_pre = hold_q.tqgl_pre;
  assign bus.disp_o_alu_tqgl_cur = hold_q.tqgl_cur;
  assign bus.disp_o_alu_ntp      = hold_q.ntp;
  assign bus.disp_o_alu_fmr      = hold_q.fmr;
  assign bus.disp_o_alu_measure  = hold_q.measure;

  assign bus.disp_oitf_rs1en     = hold_q.rs1en;
  assign bus.disp_oitf_rs2en     = hold_q.rs2en;
  assign bus.disp_oitf_rdwen     = hold_q.rdwen;
  assign bus.disp_oitf_qfren     = hold_q.nqf;
  assign bus.disp_oitf_rs1idx    = hold_q.rs1idx;
  assign bus.disp_oitf_rs2idx    = hold_q.rs2idx;
  assign bus.disp_oitf_rdidx     = hold_q.rdidx;
  assign bus.disp_oitf_qubitlist = hold_q.qmr;

endmodule

// File: tb/tb_qpu_exu_dispatch.sv
// Randomized bench for qpu_exu_dispatch against a queue-based model.
// Directed reset / x0 / pass-through checks precede the random run.
module tb_qpu_exu_dispatch;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  qpu_exu_dispatch_if bus ();

  qpu_exu_dispatch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        rs1x0, rs2x0;
    logic        rs1en, rs2en, rdwen;
    logic [4:0]  rs1idx, rs2idx, rdidx;
    logic [31:0] rs1, rs2, imm, info, pc, tim;
    logic        ntp, measure, nqf, fmr;
    logic [7:0]  qmr, oprand;
    logic [65:0] edata;
    logic [47:0] tqgl_pre, tqgl_cur;
  } inst_t;

  typedef struct {
    logic m1, m2, md, mq;
    logic alu_rdy, lp, oitf_rdy, moitf_rdy;
  } env_t;

  inst_t held[$];

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic pb(int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic inst_t idle_inst();
    inst_t c;
    c = '{default: '0};
    return c;
  endfunction

  function automatic inst_t rand_inst();
    inst_t c;
    logic [95:0] r96;
    logic [63:0] r64;
    c.valid   = pb(75);
    c.rs1x0   = pb(20);
    c.rs2x0   = pb(20);
    c.rs1en   = pb(60);
    c.rs2en   = pb(60);
    c.rdwen   = pb(60);
    c.rs1idx  = 5'($urandom_range(0, 3));
    c.rs2idx  = 5'($urandom_range(0, 3));
    c.rdidx   = 5'($urandom_range(0, 3));
    c.rs1     = $urandom;
    c.rs2     = $urandom;
    c.imm     = $urandom;
    c.info    = $urandom;
    c.pc      = $urandom;
    c.tim     = $urandom;
    c.ntp     = pb(50);
    c.measure = pb(30);
    c.nqf     = pb(40);
    c.fmr     = pb(50);
    c.qmr     = 8'($urandom);
    c.oprand  = 8'($urandom);
    r96       = {$urandom, $urandom, $urandom};
    c.edata   = r96[65:0];
    r64       = {$urandom, $urandom};
    c.tqgl_pre = r64[47:0];
    r64       = {$urandom, $urandom};
    c.tqgl_cur = r64[47:0];
    return c;
  endfunction

  task automatic drive(input inst_t c, input env_t e);
    bus.disp_i_valid    = c.valid;
    bus.disp_i_rs1x0    = c.rs1x0;
    bus.disp_i_rs2x0    = c.rs2x0;
    bus.disp_i_rs1en    = c.rs1en;
    bus.disp_i_rs2en    = c.rs2en;
    bus.disp_i_rdwen    = c.rdwen;
    bus.disp_i_rs1idx   = c.rs1idx;
    bus.disp_i_rs2idx   = c.rs2idx;
    bus.disp_i_rdidx    = c.rdidx;
    bus.disp_i_rs1      = c.rs1;
    bus.disp_i_rs2      = c.rs2;
    bus.disp_i_imm      = c.imm;
    bus.disp_i_info     = c.info;
    bus.disp_i_pc       = c.pc;
    bus.disp_i_clk      = c.tim;
    bus.disp_i_ntp      = c.ntp;
    bus.disp_i_measure  = c.measure;
    bus.disp_i_nqf      = c.nqf;
    bus.disp_i_fmr      = c.fmr;
    bus.disp_i_qmr      = c.qmr;
    bus.disp_i_oprand   = c.oprand;
    bus.disp_i_edata    = c.edata;
    bus.disp_i_tqgl_pre = c.tqgl_pre;
    bus.disp_i_tqgl_cur = c.tqgl_cur;
    bus.oitfrd_match_disprs1 = e.m1;
    bus.oitfrd_match_disprs2 = e.m2;
    bus.oitfrd_match_disprd  = e.md;
    bus.oitfqf_match_dispql  = e.mq;
    bus.disp_o_alu_ready     = e.alu_rdy;
    bus.disp_o_alu_longpipe  = e.lp;
    bus.disp_oitf_ready      = e.oitf_rdy;
    bus.disp_moitf_ready     = e.moitf_rdy;
  endtask

  // Reference: the decoder may hand over an instruction only when it
  // conflicts with nothing in flight and the one slot is free or draining.
  task automatic model_cycle(input inst_t c, input env_t e);
    bit    has;
    inst_t h;
    bit    ok, fire, dep, rdy;
    has = held.size() != 0;
    h   = has ? held[0] : idle_inst();
    ok  = has && (!e.lp || e.oitf_rdy) && (!h.measure || e.moitf_rdy);
    fire = ok && e.alu_rdy;
    dep = (c.rs1en && e.m1) || (c.rs2en && e.m2) || (c.rdwen && e.md);
    if (has && h.rdwen) begin
      if (c.rs1en && h.rdidx == c.rs1idx) dep = 1;
      if (c.rs2en && h.rdidx == c.rs2idx) dep = 1;
      if (c.rdwen && h.rdidx == c.rdidx)  dep = 1;
    end
`ifdef QPU_DISP_QHAZARD_EN
    if (c.nqf && e.mq) dep = 1;
    if (has && h.measure && c.nqf) dep = 1;
`endif
    rdy = !dep && (!has || fire);
    chk("i_ready", 128'(bus.disp_i_ready), 128'(rdy));
    chk("alu_valid", 128'(bus.disp_o_alu_valid), 128'(ok));
    chk("oitf_ena", 128'(bus.disp_oitf_ena), 128'(fire && e.lp));
    chk("moitf_ena", 128'(bus.disp_moitf_ena),
        128'(fire && h.measure));
    if (has) begin
      chk("alu_rs1", 128'(bus.disp_o_alu_rs1), 128'(h.rs1));
      chk("alu_rs2", 128'(bus.disp_o_alu_rs2), 128'(h.rs2));
      chk("alu_info", 128'(bus.disp_o_alu_info), 128'(h.info));
      chk("alu_edata", 128'(bus.disp_o_alu_edata), 128'(h.edata));
      chk("alu_tqgl", 128'({bus.disp_o_alu_tqgl_pre,
                            bus.disp_o_alu_tqgl_cur}),
          128'({h.tqgl_pre, h.tqgl_cur}));
      chk("alu_misc", 128'({bus.disp_o_alu_pc, bus.disp_o_alu_clk,
                            bus.disp_o_alu_imm}),
          128'({h.pc, h.tim, h.imm}));
      chk("alu_flags", 128'({bus.disp_o_alu_ntp, bus.disp_o_alu_fmr,
                             bus.disp_o_alu_measure,
                             bus.disp_o_alu_rdwen,
                             bus.disp_o_alu_rdidx,
                             bus.disp_o_alu_qmr,
                             bus.disp_o_alu_oprand}),
          128'({h.ntp, h.fmr, h.measure, h.rdwen, h.rdidx,
                h.qmr, h.oprand}));
      chk("oitf_fields", 128'({bus.disp_oitf_rs1en,
                               bus.disp_oitf_rs2en,
                               bus.disp_oitf_rdwen,
                               bus.disp_oitf_qfren,
                               bus.disp_oitf_rs1idx,
                               bus.disp_oitf_rs2idx,
                               bus.disp_oitf_rdidx,
                               bus.disp_oitf_qubitlist}),
          128'({h.rs1en, h.rs2en, h.rdwen, h.nqf, h.rs1idx,
                h.rs2idx, h.rdidx, h.qmr}));
    end
    @(posedge clk);
    if (c.valid && rdy) begin
      inst_t n;
      n = c;
      if (c.rs1x0) n.rs1 = '0;
      if (c.rs2x0) n.rs2 = '0;
      held.delete();
      held.push_back(n);
    end else if (fire) begin
      held.delete();
    end
  endtask

  inst_t c;
  env_t  e;
  env_t  e_idle;

  initial begin
    checks = 0;
    errors = 0;
    e_idle = '{default: 1'b0};
    rst_n  = 1'b0;
    drive(idle_inst(), e_idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_ready", 128'(bus.disp_i_ready), 128'(1));
    chk("rst_alu_valid", 128'(bus.disp_o_alu_valid), 128'(0));
    chk("rst_alu_rs1", 128'(bus.disp_o_alu_rs1), 128'(0));
    chk("rst_qubitlist", 128'(bus.disp_oitf_qubitlist), 128'(0));
    rst_n = 1'b1;

    // x0 operand zeroing and timing pass-through, ALU stalled
    @(negedge clk);
    c = idle_inst();
    c.valid = 1'b1;
    c.rs1x0 = 1'b1;
    c.rs1   = 32'h55;
    c.rs2   = 32'h1234;
    c.tim   = 32'd6;
    drive(c, e_idle);
    @(negedge clk);
    drive(idle_inst(), e_idle);
    #1;
    chk("x0_alu_valid", 128'(bus.disp_o_alu_valid), 128'(1));
    chk("x0_alu_rs1", 128'(bus.disp_o_alu_rs1), 128'(0));
    chk("x0_alu_rs2", 128'(bus.disp_o_alu_rs2), 128'(32'h1234));
    chk("pass_clk", 128'(bus.disp_o_alu_clk), 128'(6));
    chk("held_i_ready", 128'(bus.disp_i_ready), 128'(0));

    // reset while holding discards the instruction
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bus.disp_o_alu_valid), 128'(0));
    chk("mid_rst_ready", 128'(bus.disp_i_ready), 128'(1));
    chk("mid_rst_clk", 128'(bus.disp_o_alu_clk), 128'(0));
    chk("mid_rst_ena", 128'({bus.disp_oitf_ena,
                              bus.disp_moitf_ena}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    held.delete();

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      c = rand_inst();
      e.m1        = pb(15);
      e.m2        = pb(15);
      e.md        = pb(15);
      e.mq        = pb(20);
      e.alu_rdy   = pb(70);
      e.lp        = pb(30);
      e.oitf_rdy  = pb(70);
      e.moitf_rdy = pb(70);
      drive(c, e);
      #1;
      model_cycle(c, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
